// File: rtl/sram_like_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_axi_bridge_pkg
// Shared definitions for the SRAM-like to AXI3 bridge:
//   - read / write FSM state types
//   - fixed AXI encodings (single-beat INCR bursts)
//   - default transaction IDs for the inst and data ports
//   - size/offset to write-strobe helper
// -----------------------------------------------------------------------------
package sram_like_axi_bridge_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_R    = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_AWW  = 2'd1,
      W_B    = 2'd2
   } wr_state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [7:0] LEN_SINGLE  = 8'd0;

   localparam logic [3:0] ID_INST_DEF = 4'd0;
   localparam logic [3:0] ID_DATA_DEF = 4'd1;

   localparam logic [1:0] SIZE_BYTE   = 2'd0;
   localparam logic [1:0] SIZE_HALF   = 2'd1;

   // Byte lanes touched by a transfer of the given size at the given offset.
   // Any size other than byte/half is treated as a full word.
   function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                input logic [1:0] offset);
      logic [3:0] strb;
      case (size)
         SIZE_BYTE: strb = 4'b0001 << offset;
         SIZE_HALF: strb = offset[1] ? 4'b1100 : 4'b0011;
         default:   strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/sram_like_axi_bridge_axi_wstrb_gen.sv
// -----------------------------------------------------------------------------
// axi_wstrb_gen
// Combinational write-strobe generator.
// Ports:
//   size   in  2  0=byte 1=half 2=word
//   offset in  2  byte address bits [1:0]
//   wstrb  out 4  AXI byte-lane strobes
// -----------------------------------------------------------------------------
module axi_wstrb_gen
   import sram_like_axi_bridge_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] offset,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = size_to_wstrb(size, offset);
   end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// -----------------------------------------------------------------------------
// sram_like_axi_bridge
// Bridges the inst and data SRAM-like ports of the cache layer onto a single
// AXI3 master. One outstanding read (inst or data) and one outstanding data
// write, single-beat transfers only.
// Ports:
//   aclk, aresetn                clock, asynchronous active-low reset
//   inst_*                       SRAM-like instruction port (reads only)
//   data_*                       SRAM-like data port (reads and writes)
//   ar*/r*                       AXI read address / read data channels
//   aw*/w*/b*                    AXI write address / data / response channels
// -----------------------------------------------------------------------------
module sram_like_axi_bridge
   import sram_like_axi_bridge_pkg::*;
#(
   parameter logic [3:0] ID_INST = ID_INST_DEF,
   parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
   input  logic        aclk,
   input  logic        aresetn,
   // instruction port
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   // data port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   // AXI read address
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AXI write address
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI write data
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // AXI write response
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   rd_state_t   r_state, r_next;
   wr_state_t   w_state, w_next;

   logic [31:0] rd_addr;
   logic [1:0]  rd_size;
   logic [3:0]  rd_id;
   logic        rd_is_data;

   logic [31:0] wr_addr;
   logic [1:0]  wr_size;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        aw_done, w_done;
   logic        aw_fire, w_fire;

   logic        data_rd_req, data_wr_req;
   logic        wr_busy, data_raw, inst_raw;
   logic        rd_data_sel, rd_data_ret;
   logic        wr_sel, b_done;
   logic [3:0]  strb_in;

   // Response codes, IDs and the unused inst write path carry no information
   // this bridge acts on.
   logic        unused_inputs;
   assign unused_inputs = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

   assign data_rd_req = data_req & ~data_wr;
   assign data_wr_req = data_req &  data_wr;

   // Read-after-write guard on word address. The inst side also checks a
   // write being accepted in this very cycle, since that write will still be
   // in flight when the read goes out.
   assign wr_busy  = (w_state != W_IDLE);
   assign data_raw = wr_busy && (data_addr[31:2] == wr_addr[31:2]);
   assign inst_raw = (wr_busy && (inst_addr[31:2] == wr_addr[31:2])) ||
                     (wr_sel  && (inst_addr[31:2] == data_addr[31:2]));

   axi_wstrb_gen u_wstrb (
      .size   (data_size),
      .offset (data_addr[1:0]),
      .wstrb  (strb_in)
   );

   // ---------------------------------------------------------------- read FSM
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   always_comb begin
      r_next       = r_state;
      rd_data_sel  = 1'b0;
      inst_addr_ok = 1'b0;
      arvalid      = 1'b0;
      rready       = 1'b0;
      inst_data_ok = 1'b0;
      rd_data_ret  = 1'b0;
      case (r_state)
         R_IDLE: begin
            // A data read blocked by the RAW guard lets the inst port through.
            if (data_rd_req && !data_raw) begin
               rd_data_sel = 1'b1;
               r_next      = R_AR;
            end else if (inst_req && !inst_raw) begin
               inst_addr_ok = 1'b1;
               r_next       = R_AR;
            end
         end
         R_AR: begin
            arvalid = 1'b1;
            if (arready) r_next = R_R;
         end
         R_R: begin
            rready = 1'b1;
            if (rvalid && (rid == rd_id)) begin
               r_next = R_IDLE;
               if (rd_is_data) rd_data_ret  = 1'b1;
               else            inst_data_ok = 1'b1;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_addr    <= '0;
         rd_size    <= '0;
         rd_id      <= '0;
         rd_is_data <= 1'b0;
      end else if (rd_data_sel) begin
         rd_addr    <= data_addr;
         rd_size    <= data_size;
         rd_id      <= ID_DATA;
         rd_is_data <= 1'b1;
      end else if (inst_addr_ok) begin
         rd_addr    <= inst_addr;
         rd_size    <= inst_size;
         rd_id      <= ID_INST;
         rd_is_data <= 1'b0;
      end
   end

   // --------------------------------------------------------------- write FSM
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      wr_sel  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      aw_fire = 1'b0;
      w_fire  = 1'b0;
      bready  = 1'b0;
      b_done  = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (data_wr_req) begin
               wr_sel = 1'b1;
               w_next = W_AWW;
            end
         end
         W_AWW: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            aw_fire = !aw_done && awready;
            w_fire  = !w_done  && wready;
            if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_B;
         end
         W_B: begin
            // Hold B off while a data read returns so the data port never
            // sees two data_ok sources in one cycle.
            bready = !rd_data_ret;
            if (bvalid && !rd_data_ret) begin
               b_done = 1'b1;
               w_next = W_IDLE;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (w_state == W_AWW && w_next == W_B) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_fire) aw_done <= 1'b1;
         if (w_fire)  w_done  <= 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_addr <= '0;
         wr_size <= '0;
         wr_data <= '0;
         wr_strb <= '0;
      end else if (wr_sel) begin
         wr_addr <= data_addr;
         wr_size <= data_size;
         wr_data <= data_wdata;
         wr_strb <= strb_in;
      end
   end

   // ----------------------------------------------------------------- outputs
   assign data_addr_ok = rd_data_sel | wr_sel;
   assign data_data_ok = rd_data_ret | b_done;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arid    = rd_id;
   assign araddr  = rd_addr;
   assign arlen   = LEN_SINGLE;
   assign arsize  = {1'b0, rd_size};
   assign arburst = BURST_INCR;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;

   assign awid    = ID_DATA;
   assign awaddr  = wr_addr;
   assign awlen   = LEN_SINGLE;
   assign awsize  = {1'b0, wr_size};
   assign awburst = BURST_INCR;
   assign awlock  = '0;
   assign awcache = '0;
   assign awprot  = '0;

   assign wid     = ID_DATA;
   assign wdata   = wr_data;
   assign wstrb   = wr_strb;
   assign wlast   = 1'b1;

endmodule
